// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, branch resolution, and a 34-cycle iterative
// MUL/DIVU unit that freezes upstream registers and bubbles downstream controls.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EXE_CMD,
  input  logic [31:0] Val1,
  input  logic [31:0] Val2,
  input  logic [31:0] Reg2,
  input  logic [31:0] PC_in,
  input  logic [1:0]  Br_type,
  input  logic [4:0]  Dest_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        WB_EN_in,
  output logic [31:0] ALU_result,
  output logic [31:0] Br_addr,
  output logic        Br_taken,
  output logic [31:0] Reg2_out,
  output logic [4:0]  Dest,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic        WB_EN,
  output logic        stall
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 6;
  localparam logic [3:0]  CMD_MUL  = 4'b1100;
  localparam logic [3:0]  CMD_DIVU = 4'b1110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  op_a, op_a_nxt;   // MUL: shifted multiplicand; DIVU: dividend/quotient
  logic [W-1:0]  op_b, op_b_nxt;   // MUL: shifted multiplier;   DIVU: divisor
  logic [W-1:0]  acc, acc_nxt;     // MUL: partial product;      DIVU: remainder
  logic          is_div, is_div_nxt;
  logic          fsm_stall, use_latched;
  logic          multi_cmd, br_cond;
  logic [W-1:0]  alu_single;
  logic [W:0]    rem_sh, divisor_ext;

  assign multi_cmd   = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIVU);
  assign rem_sh      = {acc, op_a[W-1]};
  assign divisor_ext = {1'b0, op_b};

  always_comb begin
    alu_single = '0;
    case (EXE_CMD)
      4'b0000: alu_single = Val1 + Val2;
      4'b0010: alu_single = Val1 - Val2;
      4'b0100: alu_single = Val1 & Val2;
      4'b0101: alu_single = Val1 | Val2;
      4'b0110: alu_single = ~(Val1 | Val2);
      4'b0111: alu_single = Val1 ^ Val2;
      4'b1000: alu_single = Val1 << Val2[4:0];
      4'b1001: alu_single = W'($signed(Val1) >>> Val2[4:0]);
      4'b1010: alu_single = Val1 >> Val2[4:0];
      default: alu_single = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      is_div <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      op_a   <= op_a_nxt;
      op_b   <= op_b_nxt;
      acc    <= acc_nxt;
      is_div <= is_div_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    op_a_nxt    = op_a;
    op_b_nxt    = op_b;
    acc_nxt     = acc;
    is_div_nxt  = is_div;
    fsm_stall   = 1'b0;
    use_latched = 1'b0;
    case (state)
      IDLE: begin
        if (multi_cmd) begin
          fsm_stall  = 1'b1;
          op_a_nxt   = Val1;
          op_b_nxt   = Val2;
          acc_nxt    = '0;
          is_div_nxt = (EXE_CMD == CMD_DIVU);
          cnt_nxt    = '0;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        fsm_stall = 1'b1;
        cnt_nxt   = CW'(cnt + CW'(1));
        if (is_div) begin
          // Restoring step; a zero divisor always subtracts, yielding all-ones.
          if (rem_sh >= divisor_ext) begin
            acc_nxt  = W'(rem_sh - divisor_ext);
            op_a_nxt = {op_a[W-2:0], 1'b1};
          end else begin
            acc_nxt  = rem_sh[W-1:0];
            op_a_nxt = {op_a[W-2:0], 1'b0};
          end
        end else begin
          if (op_b[0]) acc_nxt = acc + op_a;
          op_a_nxt = {op_a[W-2:0], 1'b0};
          op_b_nxt = {1'b0, op_b[W-1:1]};
        end
        if (cnt == CW'(W - 1)) state_nxt = DONE;
      end
      DONE: begin
        use_latched = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign br_cond = (Br_type == 2'd3) ||
                   ((Br_type == 2'd1) && (Val1 == '0)) ||
                   ((Br_type == 2'd2) && (Val1 != Reg2));

  assign stall      = fsm_stall & ~rst;
  assign ALU_result = use_latched ? (is_div ? op_a : acc) : alu_single;
  assign Br_addr    = PC_in + {Val2[W-3:0], 2'b00};
  assign Br_taken   = br_cond & ~stall & ~rst;
  assign Reg2_out   = Reg2;
  assign Dest       = Dest_in;
  assign MEM_R_EN   = MEM_R_EN_in & ~stall & ~rst;
  assign MEM_W_EN   = MEM_W_EN_in & ~stall & ~rst;
  assign WB_EN      = WB_EN_in & ~stall & ~rst;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: occupancy-based reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  EXE_CMD;
  logic [31:0] Val1, Val2, Reg2, PC_in;
  logic [1:0]  Br_type;
  logic [4:0]  Dest_in;
  logic        MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
  logic [31:0] ALU_result, Br_addr, Reg2_out;
  logic        Br_taken, MEM_R_EN, MEM_W_EN, WB_EN, stall;
  logic [4:0]  Dest;

  int compared   = 0;
  int mismatched = 0;
  int phase      = 0;  // cycles already spent by the current MUL/DIVU
  int dest_seq   = 0;

  exe_stage dut (
    .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD), .Val1(Val1), .Val2(Val2),
    .Reg2(Reg2), .PC_in(PC_in), .Br_type(Br_type), .Dest_in(Dest_in),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
    .ALU_result(ALU_result), .Br_addr(Br_addr), .Br_taken(Br_taken),
    .Reg2_out(Reg2_out), .Dest(Dest), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .WB_EN(WB_EN), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_multi(input logic [3:0] cmd);
    return (cmd == 4'd12) || (cmd == 4'd14);
  endfunction

  function automatic logic [31:0] ref_single(input logic [3:0] cmd, input logic [31:0] a, b);
    case (cmd)
      4'd0:    return a + b;
      4'd2:    return a - b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return ~(a | b);
      4'd7:    return a ^ b;
      4'd8:    return a << b[4:0];
      4'd9:    return 32'($signed(a) >>> b[4:0]);
      4'd10:   return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_multi(input logic [3:0] cmd, input logic [31:0] a, b);
    logic [63:0] p;
    if (cmd == 4'd12) begin
      p = 64'(a) * 64'(b);
      return p[31:0];
    end
    if (b == 32'd0) return 32'hFFFF_FFFF;
    return a / b;
  endfunction

  // Occupancy model: a held MUL/DIVU stalls for 33 cycles, then retires once.
  always @(posedge clk or posedge rst) begin
    if (rst) phase = 0;
    else if (is_multi(EXE_CMD)) phase = (phase >= 33) ? 0 : phase + 1;
    else phase = 0;
  end

  always @(negedge clk) begin
    logic        e_stall, e_taken;
    logic [31:0] e_alu;
    e_stall = !rst && is_multi(EXE_CMD) && (phase < 33);
    e_alu   = is_multi(EXE_CMD) ? ref_multi(EXE_CMD, Val1, Val2)
                                : ref_single(EXE_CMD, Val1, Val2);
    e_taken = !rst && !e_stall &&
              ((Br_type == 2'd3) || (Br_type == 2'd1 && Val1 == 0) ||
               (Br_type == 2'd2 && Val1 != Reg2));
    chk("m_stall", stall, e_stall);
    chk("m_br_taken", Br_taken, e_taken);
    chk("m_br_addr", Br_addr, PC_in + Val2 * 4);
    chk("m_wb_en", WB_EN, WB_EN_in && !e_stall && !rst);
    chk("m_mem_r", MEM_R_EN, MEM_R_EN_in && !e_stall && !rst);
    chk("m_mem_w", MEM_W_EN, MEM_W_EN_in && !e_stall && !rst);
    chk("m_dest", 32'(Dest), 32'(Dest_in));
    chk("m_reg2", Reg2_out, Reg2);
    if (!rst && !e_stall) chk("m_alu", ALU_result, e_alu);
  end

  task automatic drive(input logic [3:0] cmd, input logic [31:0] v1, v2, r2,
                       input logic [1:0] br, input logic wb);
    EXE_CMD     = cmd;
    Val1        = v1;
    Val2        = v2;
    Reg2        = r2;
    Br_type     = br;
    WB_EN_in    = wb;
    MEM_R_EN_in = v1[0];
    MEM_W_EN_in = v2[0];
    PC_in       = 32'h40;
    dest_seq++;
    Dest_in     = 5'(dest_seq);
  endtask

  // Hold one instruction for its full occupancy; check final-cycle result literally.
  task automatic run(input string name, input logic [3:0] cmd, input logic [31:0] v1, v2,
                     input int cycles, input logic [31:0] exp_alu);
    int stalls;
    drive(cmd, v1, v2, 32'h1234_5678, 2'd0, 1'b1);
    stalls = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (i == cycles - 1) begin
        chk({name, "_alu"}, ALU_result, exp_alu);
        chk({name, "_wb"}, 32'(WB_EN), 32'd1);
      end
    end
    chk({name, "_stall_cycles"}, stalls, cycles - 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'd0, 32'd7, 32'd5, 32'd0, 2'd0, 1'b1);
    @(negedge clk);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_wb", 32'(WB_EN), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run("add", 4'd0, 32'd7, 32'd5, 1, 32'd12);
    run("mul", 4'd12, 32'h0001_0003, 32'h0000_0005, 34, 32'h0005_000F);
    run("divu", 4'd14, 32'd100, 32'd7, 34, 32'd14);
    run("div0", 4'd14, 32'd55, 32'd0, 34, 32'hFFFF_FFFF);
    run("sll", 4'd8, 32'h0000_0003, 32'd4, 1, 32'h0000_0030);
    run("sra", 4'd9, 32'h8000_0000, 32'd4, 1, 32'hF800_0000);
    run("srl", 4'd10, 32'h8000_0000, 32'd4, 1, 32'h0800_0000);
    run("nor", 4'd6, 32'hF0F0_0000, 32'h0000_000F, 1, 32'h0F0F_FFF0);
    run("xor", 4'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 32'hF0F0_F0F0);
    run("undef", 4'd3, 32'd9, 32'd9, 1, 32'd0);

    // Flushed bubble behaves like an ADD with no writeback.
    drive(4'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0);
    @(negedge clk);
    chk("bubble_alu", ALU_result, 32'd0);
    chk("bubble_wb", 32'(WB_EN), 32'd0);
    @(posedge clk); #1;

    drive(4'd0, 32'd3, 32'hFFFF_FFFE, 32'd4, 2'd2, 1'b0);
    @(negedge clk);
    chk("bne_taken", 32'(Br_taken), 32'd1);
    chk("bne_addr", Br_addr, 32'h38);
    @(posedge clk); #1;

    drive(4'd0, 32'd1, 32'd0, 32'd0, 2'd1, 1'b0);
    @(negedge clk);
    chk("bez_taken", 32'(Br_taken), 32'd0);
    @(posedge clk); #1;

    // Reset during BUSY iteration 10, then the held MUL restarts cleanly.
    drive(4'd12, 32'd1000, 32'd3000, 32'd0, 2'd0, 1'b1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_wb", 32'(WB_EN), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run("mul_after_rst", 4'd12, 32'd1000, 32'd3000, 34, 32'd3_000_000);

    // Back-to-back: SUB enters right after DONE, MUL must not rerun.
    run("mul_b2b", 4'd12, 32'd6, 32'd7, 34, 32'd42);
    run("sub_b2b", 4'd2, 32'd9, 32'd12, 1, 32'hFFFF_FFFD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
